// File: rtl/vdma_rd_pkg.sv
// rtl/vdma_rd_pkg.sv - shared state type and arithmetic widths for the VDMA read channel
// Contents: rd_state_t scheduler states, AXI_SHIFT default beat shift,
//           BITS_W (frame bit-count width), BEATS_W (frame beat-count width).
package vdma_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT_SPACE,
        REQ,
        WAIT_DONE
    } rd_state_t;

    localparam int AXI_DSIZE_DEF = 256;
    localparam int AXI_SHIFT     = $clog2(AXI_DSIZE_DEF);
    localparam int BITS_W        = 48;
    localparam int BEATS_W       = 32;

endpackage

// File: rtl/read_burst_scheduler_if.sv
// rtl/read_burst_scheduler_if.sv - AXI read burst request/completion handshake bundle
// Signals: rd_req (burst request valid), rd_len (beats), rd_last (final burst of frame),
//          rd_ack (AR accept), rd_done (last R beat of current burst received).
// Modports: master = scheduler side, slave = AXI AR/R engine side.
interface read_burst_scheduler_if #(
    parameter int LSIZE = 9
) ();

    logic             rd_req;
    logic [LSIZE-1:0] rd_len;
    logic             rd_last;
    logic             rd_ack;
    logic             rd_done;

    modport master (
        output rd_req,
        output rd_len,
        output rd_last,
        input  rd_ack,
        input  rd_done
    );

    modport slave (
        input  rd_req,
        input  rd_len,
        input  rd_last,
        output rd_ack,
        output rd_done
    );

endinterface

// File: rtl/frame_beat_calc.sv
// rtl/frame_beat_calc.sv - two-stage pixel-count to AXI-beat-count pipeline
// Ports: clock, rst_n (async active-low), start (capture pix), pix (pixel count),
//        beats (ceil(pix*DSIZE / 2^SHIFT), saturated to BEATS_W), valid (one-cycle result pulse).
module frame_beat_calc
    import vdma_rd_pkg::*;
#(
    parameter int DSIZE = 24,
    parameter int SHIFT = AXI_SHIFT
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BEATS_W-1:0] pix,
    output logic [BEATS_W-1:0] beats,
    output logic               valid
);

    logic [BITS_W-1:0] bits_q;
    logic              bits_vld;
    logic [BITS_W-1:0] beats_full;

    // Round up: any leftover bits below one beat cost a whole extra beat.
    assign beats_full = (bits_q >> SHIFT) + BITS_W'(|bits_q[SHIFT-1:0]);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bits_q   <= '0;
            bits_vld <= 1'b0;
            beats    <= '0;
            valid    <= 1'b0;
        end else begin
            bits_vld <= start;
            // A new start flushes the result of the computation already in flight.
            valid    <= bits_vld & ~start;
            if (start) begin
                bits_q <= BITS_W'(pix) * BITS_W'(DSIZE);
            end
            if (bits_vld) begin
                beats <= (|beats_full[BITS_W-1:BEATS_W]) ? '1 : beats_full[BEATS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/read_burst_scheduler.sv
// rtl/read_burst_scheduler.sv - per-frame AXI read burst sequencer for one VDMA read channel
// Ports: clock, rst_n (async active-low), enable (level), vactive/hactive (frame geometry),
//        fsync (frame/line start pulse), fifo_space (free FIFO beats), rd (burst handshake,
//        master side), busy (not IDLE), frame_done (pulse after final burst), frame_overrun
//        (pulse on fsync while busy).
module read_burst_scheduler
    import vdma_rd_pkg::*;
#(
    parameter int NOR_BURST_LEN = 200,
    parameter int AXI_DSIZE     = 256,
    parameter int DSIZE         = 24,
    parameter int LSIZE         = 9,
    parameter     MODE          = "ONCE"
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [15:0]           vactive,
    input  logic [15:0]           hactive,
    input  logic                  fsync,
    input  logic [LSIZE:0]        fifo_space,
    read_burst_scheduler_if.master rd,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_overrun
);

    localparam int                 SHIFT     = $clog2(AXI_DSIZE);
    localparam logic [BEATS_W-1:0] NOR_LEN32 = BEATS_W'(NOR_BURST_LEN);
    localparam logic [LSIZE-1:0]   NOR_LEN   = LSIZE'(NOR_BURST_LEN);

    rd_state_t          state;
    rd_state_t          next_state;
    logic [BEATS_W-1:0] remaining;
    logic [BEATS_W-1:0] rem_after;
    logic               restart;
    logic               restart_next;
    logic [LSIZE-1:0]   len;
    logic [LSIZE-1:0]   len_q;
    logic               last_q;
    logic [BEATS_W-1:0] pix;
    logic [BEATS_W-1:0] beats;
    logic               calc_valid;
    logic               calc_start;
    logic               load_rem;
    logic               sub_rem;
    logic               load_burst;
    logic               done_set;
    logic               ovr_set;

    assign pix = (MODE == "LINE") ? BEATS_W'(hactive)
                                  : BEATS_W'(vactive) * BEATS_W'(hactive);

    frame_beat_calc #(
        .DSIZE (DSIZE),
        .SHIFT (SHIFT)
    ) u_calc (
        .clock (clock),
        .rst_n (rst_n),
        .start (calc_start),
        .pix   (pix),
        .beats (beats),
        .valid (calc_valid)
    );

    assign len       = (remaining < NOR_LEN32) ? remaining[LSIZE-1:0] : NOR_LEN;
    assign rem_after = remaining - BEATS_W'(len_q);

    assign rd.rd_req  = (state == REQ);
    assign rd.rd_len  = len_q;
    assign rd.rd_last = last_q;
    assign busy       = (state != IDLE);

    always_comb begin
        next_state   = state;
        calc_start   = 1'b0;
        load_rem     = 1'b0;
        sub_rem      = 1'b0;
        load_burst   = 1'b0;
        done_set     = 1'b0;
        ovr_set      = 1'b0;
        restart_next = restart;

        if (fsync && (state != IDLE)) begin
            ovr_set      = 1'b1;
            restart_next = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (fsync && enable) begin
                    next_state = CALC;
                    calc_start = 1'b1;
                end
            end
            CALC: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (fsync) begin
                    calc_start = 1'b1;
                end else if (calc_valid) begin
                    if (beats == '0) begin
                        done_set   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        load_rem   = 1'b1;
                        next_state = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (fsync) begin
                    next_state = CALC;
                    calc_start = 1'b1;
                end else if (fifo_space >= {1'b0, len}) begin
                    load_burst = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                // The AR request cannot be withdrawn, so fsync/enable wait for completion.
                if (rd.rd_ack) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rd.rd_done) begin
                    sub_rem = 1'b1;
                    if (fsync) begin
                        // A new frame arriving with the final rd_done supersedes frame_done.
                        next_state = enable ? CALC : IDLE;
                        calc_start = enable;
                    end else if (rem_after == '0) begin
                        done_set   = 1'b1;
                        next_state = IDLE;
                    end else if (!enable) begin
                        next_state = IDLE;
                    end else if (restart) begin
                        next_state = CALC;
                        calc_start = 1'b1;
                    end else begin
                        next_state = WAIT_SPACE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        if (calc_start || (next_state == IDLE)) begin
            restart_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            remaining     <= '0;
            restart       <= 1'b0;
            len_q         <= '0;
            last_q        <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= next_state;
            restart       <= restart_next;
            frame_done    <= done_set;
            frame_overrun <= ovr_set;
            if (load_rem) begin
                remaining <= beats;
            end else if (sub_rem) begin
                remaining <= rem_after;
            end
            if (load_burst) begin
                len_q  <= len;
                last_q <= (remaining <= NOR_LEN32);
            end
        end
    end

endmodule
